// File: rtl/data_sram_responder_if.sv
// Data-side memory bus between the MEM stage (master) and the SRAM responder (slave).
// Signals:
//   dce       request enable
//   daddr     byte address, low two bits unused
//   we, dre   byte write / read enables, bit 3 = lane [31:24]
//   din       lane-placed write data
//   dm        lane-masked read data
//   drdy      one-cycle response strobe
//   err       out-of-range flag, valid with drdy
//   stall_req pipeline hold request
interface data_sram_responder_if;
  logic        dce;
  logic [31:0] daddr;
  logic [3:0]  we;
  logic [3:0]  dre;
  logic [31:0] din;
  logic [31:0] dm;
  logic        drdy;
  logic        err;
  logic        stall_req;

  modport master (
    output dce, daddr, we, dre, din,
    input  dm, drdy, err, stall_req
  );

  modport slave (
    input  dce, daddr, we, dre, din,
    output dm, drdy, err, stall_req
  );
endinterface

// File: rtl/data_sram_responder.sv
// Data-side synchronous SRAM responder. Accepts one load/store at a time from the MEM stage,
// performs byte-lane writes into an internal word array and returns lane-masked read data after
// WAIT_CYCLES wait states, holding the pipeline with stall_req until the response.
// Ports:
//   cpu_clk_50M  clock
//   cpu_rst_n    synchronous active-low reset
//   bus          slave side of the data bus (dce/daddr/we/dre/din in; dm/drdy/err/stall_req out)
module data_sram_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic                  cpu_clk_50M,
  input logic                  cpu_rst_n,
  data_sram_responder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam logic [2:0] WaitInit = 3'(WAIT_CYCLES);

  state_e                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [3:0]              we_q, dre_q;
  logic [31:0]             din_q;
  logic                    oor_q;
  logic [31:0]             dm_q;
  logic                    drdy_q, err_q;

  logic                    req, live_oor, capture, commit, from_regs;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [3:0]              acc_we, acc_dre;
  logic [31:0]             acc_din, rd_word, rd_masked;
  logic                    acc_oor;
  logic                    unused_daddr;

  // Contents are deliberately not reset.
  logic [31:0] mem_q [2**ADDR_WIDTH];

  assign req          = bus.dce & (|(bus.we | bus.dre));
  assign live_oor     = (bus.daddr >> (ADDR_WIDTH + 2)) != 32'd0;
  assign unused_daddr = ^bus.daddr[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle, StResp: begin
        if (req) begin
          capture = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end else begin
            state_d = StResp;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = StResp;
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset on the RESP-entry edge suppresses both the write and the response.
  assign commit = cpu_rst_n & (state_d == StResp);

  // With zero wait states the access commits on the accepting edge, so use live inputs;
  // otherwise the captured request is used.
  assign from_regs = (state_q == StWait);

  always_comb begin
    acc_addr = bus.daddr[ADDR_WIDTH+1:2];
    acc_we   = bus.we;
    acc_dre  = bus.dre;
    acc_din  = bus.din;
    acc_oor  = live_oor;
    if (from_regs) begin
      acc_addr = addr_q;
      acc_we   = we_q;
      acc_dre  = dre_q;
      acc_din  = din_q;
      acc_oor  = oor_q;
    end
  end

  assign rd_word = mem_q[acc_addr];

  always_comb begin
    rd_masked = 32'd0;
    for (int i = 0; i < 4; i++) begin
      rd_masked[8*i +: 8] = acc_dre[i] ? rd_word[8*i +: 8] : 8'h00;
    end
    if (acc_oor) rd_masked = 32'd0;
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      addr_q  <= '0;
      we_q    <= 4'd0;
      dre_q   <= 4'd0;
      din_q   <= 32'd0;
      oor_q   <= 1'b0;
      dm_q    <= 32'd0;
      drdy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drdy_q  <= commit;
      if (capture) begin
        addr_q <= bus.daddr[ADDR_WIDTH+1:2];
        we_q   <= bus.we;
        dre_q  <= bus.dre;
        din_q  <= bus.din;
        oor_q  <= live_oor;
      end
      if (commit) begin
        dm_q  <= rd_masked;
        err_q <= acc_oor;
      end
    end
  end

  // Read data is sampled above on the same edge, so the read sees the pre-write word.
  always_ff @(posedge cpu_clk_50M) begin
    if (commit && !acc_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_we[i]) mem_q[acc_addr][8*i +: 8] <= acc_din[8*i +: 8];
      end
    end
  end

  assign bus.dm        = dm_q;
  assign bus.drdy      = drdy_q;
  assign bus.err       = err_q;
  assign bus.stall_req = cpu_rst_n & ((state_q != StWait & req) | (state_q == StWait));

endmodule

// File: tb/tb_data_sram_responder.sv
// Testbench for data_sram_responder: one instance with two wait states driven by randomized
// accesses against a word-array reference model, plus a zero-wait-state instance.
module tb_data_sram_responder;

  localparam int unsigned AW = 10;
  localparam int unsigned W  = 2;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  data_sram_responder_if bus ();
  data_sram_responder_if bus0 ();

  data_sram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(W)) u_dut (
    .cpu_clk_50M(clk),
    .cpu_rst_n  (rst_n),
    .bus        (bus)
  );

  data_sram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut0 (
    .cpu_clk_50M(clk),
    .cpu_rst_n  (rst_n),
    .bus        (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain word array indexed by word address.
  logic [31:0] ref_mem [2**AW];

  logic [31:0] q_addr[$];
  logic [3:0]  q_we[$];
  logic [3:0]  q_dre[$];
  logic [31:0] q_din[$];

  function automatic logic [31:0] lane_bits(input logic [3:0] m);
    logic [31:0] r;
    r = 32'd0;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_main();
    bus.dce = 1'b0; bus.daddr = 32'd0; bus.we = 4'd0; bus.dre = 4'd0; bus.din = 32'd0;
  endtask

  task automatic idle_zero();
    bus0.dce = 1'b0; bus0.daddr = 32'd0; bus0.we = 4'd0; bus0.dre = 4'd0; bus0.din = 32'd0;
  endtask

  task automatic push_req(input logic [31:0] a, input logic [3:0] w, input logic [3:0] r,
                          input logic [31:0] d);
    q_addr.push_back(a); q_we.push_back(w); q_dre.push_back(r); q_din.push_back(d);
  endtask

  // Issues all queued requests back to back on the main instance, checking stall/response timing
  // and returned data against the reference model.
  task automatic run_batch();
    int          n;
    logic [31:0] a, prev_dm, mask;
    logic        prev_err, oor;
    bit          have_prev;
    int          word;
    n = q_addr.size();
    have_prev = 1'b0;
    prev_dm = 32'd0;
    prev_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      a = q_addr[i];
      bus.dce = 1'b1; bus.daddr = a; bus.we = q_we[i]; bus.dre = q_dre[i]; bus.din = q_din[i];
      #1;
      checks++;
      if (bus.stall_req !== 1'b1) begin
        errors++; $display("FAIL accept_stall req%0d: got %b want 1", i, bus.stall_req);
      end
      checks++;
      if (bus.drdy !== have_prev) begin
        errors++; $display("FAIL accept_drdy req%0d: got %b want %b", i, bus.drdy, have_prev);
      end
      if (have_prev) begin
        checks++;
        if (bus.dm !== prev_dm || bus.err !== prev_err) begin
          errors++;
          $display("FAIL b2b_data req%0d: got dm=%h err=%b want dm=%h err=%b", i - 1, bus.dm,
                   bus.err, prev_dm, prev_err);
        end
      end
      oor  = (a >> (AW + 2)) != 32'd0;
      word = int'(a[AW+1:2]);
      prev_err = oor;
      prev_dm  = oor ? 32'd0 : (ref_mem[word] & lane_bits(q_dre[i]));
      if (!oor) begin
        mask = lane_bits(q_we[i]);
        ref_mem[word] = (ref_mem[word] & ~mask) | (q_din[i] & mask);
      end
      have_prev = 1'b1;
      for (int k = 0; k < W; k++) begin
        tick(); #1;
        checks++;
        if (bus.stall_req !== 1'b1 || bus.drdy !== 1'b0) begin
          errors++;
          $display("FAIL wait_cycle req%0d k%0d: got stall=%b drdy=%b want stall=1 drdy=0", i, k,
                   bus.stall_req, bus.drdy);
        end
      end
    end
    @(posedge clk); #1;
    idle_main();
    #1;
    checks++;
    if (bus.drdy !== 1'b1 || bus.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL resp_strobe: got drdy=%b stall=%b want drdy=1 stall=0", bus.drdy,
               bus.stall_req);
    end
    checks++;
    if (bus.dm !== prev_dm || bus.err !== prev_err) begin
      errors++;
      $display("FAIL resp_data: got dm=%h err=%b want dm=%h err=%b", bus.dm, bus.err, prev_dm,
               prev_err);
    end
    q_addr.delete(); q_we.delete(); q_dre.delete(); q_din.delete();
  endtask

  task automatic test_reset();
    bus.dce = 1'b1; bus.we = 4'hF; bus.daddr = 32'h10;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin
      errors++; $display("FAIL reset_stall_gate: got %b want 0", bus.stall_req);
    end
    idle_main();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.drdy !== 1'b0 || bus.err !== 1'b0 || bus.dm !== 32'd0 || bus.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got drdy=%b err=%b dm=%h stall=%b want all 0", bus.drdy,
               bus.err, bus.dm, bus.stall_req);
    end
    checks++;
    if (bus0.drdy !== 1'b0 || bus0.err !== 1'b0 || bus0.dm !== 32'd0) begin
      errors++;
      $display("FAIL reset_values_w0: got drdy=%b err=%b dm=%h want all 0", bus0.drdy, bus0.err,
               bus0.dm);
    end
  endtask

  task automatic test_zero_wait();
    tick();
    bus0.dce = 1'b1; bus0.daddr = 32'h10; bus0.we = 4'hF; bus0.dre = 4'h0; bus0.din = 32'hDEADBEEF;
    #1;
    checks++;
    if (bus0.stall_req !== 1'b1 || bus0.drdy !== 1'b0) begin
      errors++;
      $display("FAIL w0_store_accept: got stall=%b drdy=%b want 1 0", bus0.stall_req, bus0.drdy);
    end
    tick();
    bus0.we = 4'h0; bus0.dre = 4'hF; bus0.din = 32'd0;
    #1;
    checks++;
    if (bus0.drdy !== 1'b1 || bus0.dm !== 32'd0 || bus0.err !== 1'b0 || bus0.stall_req !== 1'b1)
    begin
      errors++;
      $display("FAIL w0_store_resp: got drdy=%b dm=%h err=%b stall=%b want 1 0 0 1", bus0.drdy,
               bus0.dm, bus0.err, bus0.stall_req);
    end
    tick();
    idle_zero();
    #1;
    checks++;
    if (bus0.drdy !== 1'b1 || bus0.dm !== 32'hDEADBEEF || bus0.err !== 1'b0 ||
        bus0.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL w0_load_resp: got drdy=%b dm=%h err=%b stall=%b want 1 deadbeef 0 0",
               bus0.drdy, bus0.dm, bus0.err, bus0.stall_req);
    end
    tick(); #1;
    checks++;
    if (bus0.drdy !== 1'b0 || bus0.dm !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL w0_hold: got drdy=%b dm=%h want 0 deadbeef", bus0.drdy, bus0.dm);
    end
  endtask

  task automatic test_preload();
    for (int i = 0; i < 32; i++) push_req(32'(i * 4), 4'hF, 4'h0, $urandom);
    run_batch();
  endtask

  task automatic test_lanes();
    push_req(32'h10, 4'hF, 4'h0, 32'h0);
    push_req(32'h10, 4'b0100, 4'h0, 32'hAAAAAAAA);
    push_req(32'h10, 4'h0, 4'hF, 32'h0);
    run_batch();
    checks++;
    if (bus.dm !== 32'h00AA0000) begin
      errors++; $display("FAIL lane_write: got %h want 00aa0000", bus.dm);
    end
    push_req(32'h14, 4'hF, 4'h0, 32'h11223344);
    push_req(32'h14, 4'h0, 4'b0011, 32'h0);
    run_batch();
    checks++;
    if (bus.dm !== 32'h00003344) begin
      errors++; $display("FAIL lane_read: got %h want 00003344", bus.dm);
    end
    // Read-before-write within one access.
    push_req(32'h14, 4'hF, 4'hF, 32'h55667788);
    run_batch();
    checks++;
    if (bus.dm !== 32'h11223344) begin
      errors++; $display("FAIL read_before_write: got %h want 11223344", bus.dm);
    end
  endtask

  task automatic test_ignore();
    tick();
    bus.dce = 1'b1; bus.daddr = 32'h10; bus.we = 4'h0; bus.dre = 4'h0;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin
      errors++; $display("FAIL empty_mask_stall: got %b want 0", bus.stall_req);
    end
    tick();
    bus.dce = 1'b0; bus.we = 4'hF; bus.dre = 4'hF;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0 || bus.drdy !== 1'b0) begin
      errors++;
      $display("FAIL no_dce: got stall=%b drdy=%b want 0 0", bus.stall_req, bus.drdy);
    end
    tick(); #1;
    checks++;
    if (bus.drdy !== 1'b0) begin
      errors++; $display("FAIL ignored_drdy: got %b want 0", bus.drdy);
    end
    idle_main();
  endtask

  task automatic test_oor();
    push_req(32'h00001000, 4'hF, 4'h0, 32'hFFFFFFFF);
    run_batch();
    checks++;
    if (bus.err !== 1'b1) begin
      errors++; $display("FAIL oor_store_err: got %b want 1", bus.err);
    end
    push_req(32'h00001000, 4'h0, 4'hF, 32'h0);
    push_req(32'h00000000, 4'h0, 4'hF, 32'h0);
    run_batch();
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [3:0]  w, r;
    for (int i = 0; i < 60; i++) begin
      a = {20'd0, 5'($urandom_range(0, 31)), 5'd0, 2'($urandom)};
      a[9:2] = 8'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) a = a | {20'($urandom_range(1, 20'hFFFFF)), 12'd0};
      w = 4'($urandom);
      r = 4'($urandom);
      if (w == 4'd0 && r == 4'd0) r = 4'hF;
      push_req(a, w, r, $urandom);
      if ($urandom_range(0, 2) == 0) run_batch();
    end
    run_batch();
  endtask

  task automatic test_back_to_back();
    push_req(32'h20, 4'hF, 4'h0, 32'hA5A55A5A);
    push_req(32'h20, 4'h0, 4'hF, 32'h0);
    push_req(32'h24, 4'b1001, 4'b0110, 32'h12345678);
    run_batch();
  endtask

  task automatic test_reset_mid();
    push_req(32'h18, 4'hF, 4'h0, 32'hCAFEF00D);
    push_req(32'h18, 4'h0, 4'hF, 32'h0);
    run_batch();
    tick();
    bus.dce = 1'b1; bus.daddr = 32'h18; bus.we = 4'hF; bus.dre = 4'h0; bus.din = 32'h12345678;
    repeat (W) tick();
    // Last wait cycle: reset is sampled on the edge that would commit the write.
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.stall_req !== 1'b0) begin
      errors++; $display("FAIL mid_reset_stall: got %b want 0", bus.stall_req);
    end
    tick();
    #1;
    checks++;
    if (bus.drdy !== 1'b0 || bus.dm !== 32'd0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got drdy=%b dm=%h err=%b want 0", bus.drdy, bus.dm,
               bus.err);
    end
    idle_main();
    rst_n = 1'b1;
    tick(); #1;
    checks++;
    if (bus.drdy !== 1'b0 || bus.stall_req !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got drdy=%b stall=%b want 0 0", bus.drdy, bus.stall_req);
    end
    push_req(32'h18, 4'h0, 4'hF, 32'h0);
    run_batch();
    checks++;
    if (bus.dm !== 32'hCAFEF00D) begin
      errors++; $display("FAIL reset_no_commit: got %h want cafef00d", bus.dm);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_main();
    idle_zero();
    for (int i = 0; i < 2**AW; i++) ref_mem[i] = 32'd0;
    repeat (3) tick();
    test_reset();
    test_zero_wait();
    test_preload();
    test_lanes();
    test_ignore();
    test_oor();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Data-side synchronous SRAM responder: the slave end of the MEM-stage data interface (`dce`/`daddr`/`we`/`dre`/`din`). It captures one load/store request at a time and performs byte-lane writes into an internal word array. It returns lane-masked read data after a parameterised number of wait states, holding the pipeline with `stall_req` until the response. It sits between the MEM stage and the WB-stage load aligner and replaces the ideal single-cycle data RAM in simulation and FPGA builds.

## Interface
- `ADDR_WIDTH`, 10: word-address bits; array depth is 2^ADDR_WIDTH words.
- `WAIT_CYCLES`, 1: wait states per access, legal range 0..7.

Ports:
- `cpu_clk_50M`  in  1  clock.
- `cpu_rst_n`  in  1  one clock; reset is synchronous and active-low.
- `dce`  in  1  request enable from MEM stage.
- `daddr`  in  32  byte address; `daddr[1:0]` is ignored (lanes selected by `we`/`dre`).
- `we`  in  4  byte write enables; bit 3 = lane [31:24] = byte offset 0.
- `dre`  in  4  byte read enables, same lane mapping.
- `din`  in  32  write data, already lane-placed by MEM stage.
- `dm`  out  32  read data, lane-masked.
- `drdy`  out  1  one-cycle response strobe.
- `err`  out  1  out-of-range flag, valid with `drdy`.
- `stall_req`  out  1  pipeline hold request (combinational).

## Operation
- Request: `dce=1` and `(we|dre)!=0`. `dce=1` with both masks zero is ignored.
- States: IDLE, WAIT, RESP.
  - IDLE or RESP + request → capture `daddr[ADDR_WIDTH+1:2]`, `we`, `dre`, `din`, and the range check. Next state is WAIT (load counter with WAIT_CYCLES) if WAIT_CYCLES>0, else RESP.
  - IDLE or RESP, no request → IDLE.
  - WAIT: decrement counter; at 1 → RESP.
  - RESP: `drdy=1` for this cycle only.
- Range check: out of range if `daddr[31:ADDR_WIDTH+2]!=0`. Out-of-range write is dropped; read returns 0; `err=1` with `drdy`.
- Write commit is on the clock edge entering RESP. Each lane i with `we[i]=1` updates byte i; other lanes are unchanged.
- Read is captured on the same edge, before the write (read-before-write when both masks are nonzero). `dm` lane i = stored byte i if `dre[i]`, else 0x00.
- `stall_req = cpu_rst_n & ((state∈{IDLE,RESP} & request) | state==WAIT)`.
- MEM stage holds request signals stable while `stall_req=1`. Only captured values are used.
- Array contents are not initialised or cleared by reset; the bench preloads them.

## Timing
- Request accepted at cycle T: `stall_req=1` in cycles T..T+WAIT_CYCLES; RESP and `drdy=1` at T+WAIT_CYCLES+1.
  - WAIT_CYCLES=0: `drdy` at T+1, `stall_req` only at T.
- Back-to-back: a request present in the RESP cycle is accepted there, giving zero idle cycles between accesses. Throughput is one access per WAIT_CYCLES+1 cycles.
- `dm`, `err`: registered, updated on the edge entering RESP, held otherwise.
- `drdy`: registered.
- Reset values: state=IDLE, counter=0, `drdy=0`, `err=0`, `dm=0x00000000`, `stall_req=0`.
- Reset mid-access (in WAIT): next state is IDLE, and the pending write is never committed.
- Reset asserted on the RESP-entry edge wins; no write occurs.

## Test plan
- WAIT_CYCLES=0: store `we=1111`, `daddr=0x10`, `din=0xDEADBEEF`, then load `dre=1111`, `daddr=0x10` → `drdy` one cycle after each accept; load returns `dm=0xDEADBEEF`, `err=0`.
- Byte lanes: preload 0x00000000 at word 4; store `we=0100`, `din=0xAAAAAAAA` → word becomes 0x00AA0000. Load `dre=0011` on word 0x11223344 → `dm=0x00003344`.
- WAIT_CYCLES=2: single load accepted at T → `stall_req` high T..T+2, `drdy` only at T+3, array unchanged.
- Out of range, ADDR_WIDTH=10: store to `daddr=0x00001000` → `err=1` with `drdy`, no array change. Load at same address → `dm=0`, `err=1`.
- Back-to-back, WAIT_CYCLES=1: three consecutive requests → `drdy` pulses at T+2, T+4, T+6; `stall_req` low only at T+2 and T+4 when no new request is present, else high.
- Reset in WAIT, WAIT_CYCLES=3: store `0x12345678` accepted, `cpu_rst_n=0` at T+2 → all outputs 0 next cycle, no `drdy`. Subsequent load of that word returns the old contents.
